// File: rtl/stage_reader_if.sv
// Handshake and RAM-port bundle between the stage-buffer reader, the stage RAM and the butterfly unit.
// The slave modport is the reader's view; the master modport is the surrounding control/RAM/consumer side.
interface stage_reader_if #(
   parameter int N     = 8,
   parameter int LOG_N = 3,
   parameter int WIDTH = 32
);
   logic               start;
   logic [LOG_N-1:0]   stage_idx;
   logic [LOG_N-1:0]   rd_addr0;
   logic [LOG_N-1:0]   rd_addr1;
   logic [WIDTH-1:0]   rd_data0;
   logic [WIDTH-1:0]   rd_data1;
   logic [WIDTH-1:0]   out_data0;
   logic [WIDTH-1:0]   out_data1;
   logic [LOG_N-1:0]   out_addr0;
   logic [LOG_N-1:0]   out_addr1;
   logic [LOG_N-2:0]   out_tw;
   logic               out_nd;
   logic               out_ready;
   logic               busy;
   logic               done;
   logic               error;

   modport slave (
      input  start, stage_idx, rd_data0, rd_data1, out_ready,
      output rd_addr0, rd_addr1, out_data0, out_data1, out_addr0, out_addr1,
             out_tw, out_nd, busy, done, error
   );

   modport master (
      output start, stage_idx, rd_data0, rd_data1, out_ready,
      input  rd_addr0, rd_addr1, out_data0, out_data1, out_addr0, out_addr1,
             out_tw, out_nd, busy, done, error
   );
endinterface

// File: rtl/stage_reader.sv
// Walks the N/2 radix-2 DIT butterflies of one FFT stage, reading operand pairs from a
// combinational-read stage RAM and handing them to the butterfly unit over valid/ready.
module stage_reader #(
   parameter int N     = 8,
   parameter int LOG_N = 3,
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   stage_reader_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam logic [LOG_N-2:0] K_LAST      = (LOG_N-1)'(N/2 - 1);
   localparam logic [LOG_N:0]   STAGE_LIMIT = (LOG_N+1)'(LOG_N);

   state_t             state_q, state_d;
   logic [LOG_N-2:0]   k_q, k_d;
   logic [LOG_N-1:0]   stage_q, stage_d;
   logic [WIDTH-1:0]   out_data0_q, out_data0_d;
   logic [WIDTH-1:0]   out_data1_q, out_data1_d;
   logic [LOG_N-1:0]   out_addr0_q, out_addr0_d;
   logic [LOG_N-1:0]   out_addr1_q, out_addr1_d;
   logic [LOG_N-2:0]   out_tw_q, out_tw_d;
   logic               out_nd_q, out_nd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic [LOG_N-1:0]   k_ext;
   logic [LOG_N-1:0]   span;
   logic [LOG_N-1:0]   pos;
   logic [LOG_N-1:0]   tw_shift;
   logic [LOG_N-1:0]   map_addr0;
   logic [LOG_N-1:0]   map_addr1;
   logic [LOG_N-2:0]   map_tw;
   logic               load;

   // Butterfly k of stage s pairs the elements span apart inside block k>>s; twiddle scales pos up to N/2.
   always_comb begin
      k_ext     = {1'b0, k_q};
      span      = LOG_N'(1) << stage_q;
      pos       = k_ext & (span - 1'b1);
      map_addr0 = ((k_ext >> stage_q) << (stage_q + 1'b1)) | pos;
      map_addr1 = map_addr0 + span;
      tw_shift  = LOG_N'(LOG_N - 1) - stage_q;
      map_tw    = (LOG_N-1)'(pos << tw_shift);
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      stage_d     = stage_q;
      out_data0_d = out_data0_q;
      out_data1_d = out_data1_q;
      out_addr0_d = out_addr0_q;
      out_addr1_d = out_addr1_q;
      out_tw_d    = out_tw_q;
      out_nd_d    = out_nd_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if ({1'b0, bus.stage_idx} >= STAGE_LIMIT) begin
                  error_d = 1'b1;
               end else begin
                  stage_d = bus.stage_idx;
                  k_d     = '0;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.start) error_d = 1'b1;
            // A pair may be loaded on the same edge the previous one is handed off.
            load = !out_nd_q || bus.out_ready;
            if (load) begin
               out_data0_d = bus.rd_data0;
               out_data1_d = bus.rd_data1;
               out_addr0_d = map_addr0;
               out_addr1_d = map_addr1;
               out_tw_d    = map_tw;
               out_nd_d    = 1'b1;
               if (k_q == K_LAST) state_d = FLUSH;
               else               k_d     = k_q + 1'b1;
            end
         end
         FLUSH: begin
            if (bus.start) error_d = 1'b1;
            if (out_nd_q && bus.out_ready) begin
               out_nd_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               k_d      = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         stage_q     <= '0;
         out_data0_q <= '0;
         out_data1_q <= '0;
         out_addr0_q <= '0;
         out_addr1_q <= '0;
         out_tw_q    <= '0;
         out_nd_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         stage_q     <= stage_d;
         out_data0_q <= out_data0_d;
         out_data1_q <= out_data1_d;
         out_addr0_q <= out_addr0_d;
         out_addr1_q <= out_addr1_d;
         out_tw_q    <= out_tw_d;
         out_nd_q    <= out_nd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.rd_addr0  = map_addr0;
   assign bus.rd_addr1  = map_addr1;
   assign bus.out_data0 = out_data0_q;
   assign bus.out_data1 = out_data1_q;
   assign bus.out_addr0 = out_addr0_q;
   assign bus.out_addr1 = out_addr1_q;
   assign bus.out_tw    = out_tw_q;
   assign bus.out_nd    = out_nd_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;

endmodule

// File: tb/tb_stage_reader.sv
// Self-checking bench for stage_reader: a behavioural RAM plus a block/offset model of the DIT
// butterfly order, checked against the reader under full, toggling and random backpressure.
module tb_stage_reader;
   localparam int N     = 8;
   localparam int LOG_N = 3;
   localparam int WIDTH = 32;

   typedef struct {
      int a0;
      int a1;
      int tw;
   } pair_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] ram [N];
   pair_t            expQ[$];
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   stage_reader_if #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) bus ();

   stage_reader #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Stage RAM with combinational read.
   always_comb begin
      bus.rd_data0 = ram[bus.rd_addr0];
      bus.rd_data1 = ram[bus.rd_addr1];
   end

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit st, input int s, input bit rdy);
      bus.start     = st;
      bus.stage_idx = LOG_N'(s);
      bus.out_ready = rdy;
   endtask

   // Stage s splits the buffer into blocks of 2*span; element j of each block pairs with j+span.
   function automatic void buildExpected(input int s);
      int span;
      pair_t p;
      expQ.delete();
      span = 1 << s;
      for (int base = 0; base < N; base += 2 * span) begin
         for (int j = 0; j < span; j++) begin
            p.a0 = base + j;
            p.a1 = base + j + span;
            p.tw = j * (N / (2 * span));
            expQ.push_back(p);
         end
      end
   endfunction

   function automatic logic [71:0] outVec();
      return {bus.out_addr0, bus.out_addr1, bus.out_tw, bus.out_data0, bus.out_data1};
   endfunction

   task automatic fillRandom();
      for (int i = 0; i < N; i++) ram[i] = $urandom;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode 0: ready always high, 1: ready high on even cycles, 2: random ready.
   task automatic runPass(input int s, input int mode, input bit midStart);
      int          firstC, lastHs, doneAt, doneCount, pairs;
      bit          stalled, rdy;
      logic [71:0] snap;
      pair_t       e;
      buildExpected(s);
      firstC = -1; lastHs = -100; doneAt = -1; doneCount = 0; pairs = 0;
      stalled = 1'b0; snap = '0;
      @(negedge clk);
      applyStimulus(1'b1, s, 1'b0);
      for (int c = 0; c < 200 && doneCount == 0; c++) begin
         @(negedge clk);
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = (c % 2 == 0);
         else                rdy = 1'($urandom_range(0, 1));
         applyStimulus(midStart && c == 1, (midStart && c == 1) ? 1 : s, rdy);
         if (c == 0) begin
            checkOutput("busy_after_start", bus.busy, 1);
            checkOutput("nd_after_start", bus.out_nd, 0);
         end
         if (stalled) checkOutput("hold_while_stalled", outVec(), snap);
         stalled = 1'b0;
         if (bus.out_nd === 1'b1 && firstC < 0) firstC = c;
         if (bus.done === 1'b1) begin
            doneCount++;
            doneAt = c;
            checkOutput("done_after_last_handshake", c, lastHs + 1);
            checkOutput("pairs_per_pass", pairs, N / 2);
            checkOutput("busy_cleared", bus.busy, 0);
            checkOutput("nd_cleared", bus.out_nd, 0);
            checkOutput("idle_rd_addr", {bus.rd_addr0, bus.rd_addr1}, {3'd0, LOG_N'(1 << s)});
         end else if (bus.out_nd === 1'b1) begin
            if (rdy) begin
               if (expQ.size() == 0) begin
                  checkOutput("extra_pair", bus.out_nd, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("pair", outVec(),
                              {LOG_N'(e.a0), LOG_N'(e.a1), (LOG_N-1)'(e.tw), ram[e.a0], ram[e.a1]});
                  pairs++;
                  lastHs = c;
               end
            end else begin
               stalled = 1'b1;
               snap    = outVec();
            end
         end
      end
      checkOutput("pass_completed", doneCount, 1);
      if (mode == 0) begin
         checkOutput("first_nd_latency", firstC, 1);
         checkOutput("done_latency", doneAt, 5);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         applyStimulus(1'b0, s, 1'b1);
         checkOutput("single_done", bus.done, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 0, 1'b0);
      fillRandom();
      #12;
      checkOutput("reset_outputs", {outVec(), bus.out_nd, bus.busy, bus.done, bus.error}, 0);
      checkOutput("reset_rd_addr", {bus.rd_addr0, bus.rd_addr1}, {3'd0, 3'd1});
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] stage 0, ready high");
      runPass(0, 0, 1'b0);

      $display("[TB] stage 1, ram[i]=i+16");
      for (int i = 0; i < N; i++) ram[i] = 32'(i + 16);
      runPass(1, 0, 1'b0);

      $display("[TB] stage 2, toggling ready");
      fillRandom();
      runPass(2, 1, 1'b0);

      $display("[TB] random passes");
      for (int r = 0; r < 4; r++) begin
         fillRandom();
         runPass(int'($urandom_range(0, LOG_N - 1)), 2, 1'b0);
      end
      checkOutput("no_error_legal_passes", bus.error, 0);

      $display("[TB] start while busy");
      runPass(1, 0, 1'b1);
      checkOutput("error_on_busy_start", bus.error, 1);

      $display("[TB] illegal stage");
      doReset();
      checkOutput("error_cleared_by_reset", bus.error, 0);
      @(negedge clk);
      applyStimulus(1'b1, 3, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         checkOutput("illegal_busy", bus.busy, 0);
         checkOutput("illegal_nd", bus.out_nd, 0);
         @(negedge clk);
      end
      checkOutput("illegal_error", bus.error, 1);

      $display("[TB] reset mid-pass");
      doReset();
      @(negedge clk);
      applyStimulus(1'b1, 0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         applyStimulus(1'b0, 0, 1'b1);
      end
      checkOutput("third_pair_addr0", bus.out_addr0, 4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", {outVec(), bus.out_nd, bus.busy, bus.done, bus.error}, 0);
      checkOutput("async_reset_rd_addr0", bus.rd_addr0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("no_done_after_reset", bus.done, 0);
      end
      fillRandom();
      runPass(0, 0, 1'b0);
      checkOutput("no_error_after_fresh_pass", bus.error, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stage_reader.md
Name: stage_reader

Overview:
- Read-side sequencer for one FFT stage buffer; the write side is the FFT stage RAM.
- On a start pulse it walks all N/2 radix-2 DIT butterflies of the selected stage and drives two read addresses into the stage RAM, whose read is combinational.
- It captures both read words and the matching twiddle index into an output register, then presents them downstream with a valid/ready handshake.
- Sits between a filled stage buffer and the butterfly unit.

Parameters:
- N, 8, FFT length (power of two, >=4)
- LOG_N, 3, log2(N)
- WIDTH, 32, data word width (complex, packed)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a stage pass
- stage_idx  input  LOG_N  stage number s, 0..LOG_N-1; sampled with start
- rd_addr0  output  LOG_N  read address A to stage RAM
- rd_addr1  output  LOG_N  read address B to stage RAM
- rd_data0  input  WIDTH  RAM word at rd_addr0, same cycle
- rd_data1  input  WIDTH  RAM word at rd_addr1, same cycle
- out_data0  output  WIDTH  butterfly operand A
- out_data1  output  WIDTH  butterfly operand B
- out_addr0  output  LOG_N  address of operand A (for write-back)
- out_addr1  output  LOG_N  address of operand B
- out_tw  output  LOG_N-1  twiddle index
- out_nd  output  1  output register holds valid data
- out_ready  input  1  downstream accepts when high with out_nd
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse after the last pair is accepted
- error  output  1  sticky; set by an illegal start

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counter k=0, stored stage=0.
- Address map for butterfly k (0..N/2-1) at stage s:
  - span = 1<<s; pos = k & (span-1)
  - addr0 = ((k>>s)<<(s+1)) | pos; addr1 = addr0 + span
  - tw = pos << (LOG_N-1-s)
  - All values are unsigned, truncated to port width.
- rd_addr0/rd_addr1 are combinational from the stored stage and k in every state. In IDLE k=0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: on start, latch stage_idx, k=0, busy<=1, go to RUN.
  - RUN: a "load" occurs when (!out_nd || out_ready). On load:
    - out_data0/1 <= rd_data0/1; out_addr0/1 and out_tw <= current map values; out_nd <= 1
    - if k==N/2-1, go to FLUSH; else k <= k+1
    - With no load, all output-register contents hold stable.
  - FLUSH: when out_nd && out_ready, set out_nd<=0, busy<=0, done<=1 for one cycle, k<=0, go to IDLE.
- Throughput and latency:
  - With out_ready held high: one pair per cycle.
  - First out_nd is seen in the cycle after the cycle containing start+1, i.e. start at cycle t → RUN at t+1 → out_nd high from t+2.
  - N/2 pairs are emitted consecutively; done fires one cycle after the last handshake edge.
- Backpressure: while out_nd && !out_ready, out_* are frozen and k does not advance.
- Handshake transfer: occurs on a rising edge where out_nd && out_ready. A new pair may load on that same edge (RUN).
- start while busy: ignored, error<=1 (sticky until reset); the pass continues unaffected.
- stage_idx >= LOG_N at start: error<=1, no pass starts, stay in IDLE.
- Reset mid-pass: immediate return to the reset state; no done pulse.
- No data checks are made on rd_data; values pass through unmodified.

Test Plan:
- N=8, start with s=0, out_ready=1 → pairs (0,1),(2,3),(4,5),(6,7), tw all 0, on 4 consecutive cycles starting t+2; done at t+6.
- N=8, s=1, RAM[i]=i+16 → addrs (0,2)/(1,3)/(4,6)/(5,7), tw 0,2,0,2; out_data = addr+16.
- N=8, s=2, out_ready toggling 1,0,1,0 → pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3, each held stable while ready=0; no pair dropped or duplicated.
- Second start mid-pass (s=1) → error=1, pass completes with exactly 4 pairs, one done pulse.
- start with stage_idx=3 (N=8) → error=1, busy stays 0, out_nd stays 0.
- Deassert rst_n during the 3rd pair → all outputs 0 asynchronously; after release, a fresh s=0 pass is correct.
